// File: rtl/bk_sram_arbiter_if.sv
// BK SRAM arbiter bus bundle: CPU port, video fetch port, SRAM pins.
// master = arbiter side, slave = core/video/SRAM side.
interface bk_sram_arbiter_if;
    logic        cpu_rd;
    logic        cpu_wt;
    logic        cpu_byte;
    logic [15:0] cpu_adr;
    logic [15:0] cpu_data_i;
    logic [15:0] cpu_data_o;
    logic        cpu_reply;
    logic        vid_req;
    logic [14:0] vid_adr;
    logic [15:0] vid_data;
    logic        vid_ack;
    logic [14:0] sram_a;
    logic [15:0] sram_dq_i;
    logic [15:0] sram_dq_o;
    logic        sram_dq_oe;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_ub_n;
    logic        sram_lb_n;

    modport master (
        input  cpu_rd, cpu_wt, cpu_byte, cpu_adr, cpu_data_i,
        input  vid_req, vid_adr, sram_dq_i,
        output cpu_data_o, cpu_reply, vid_data, vid_ack,
        output sram_a, sram_dq_o, sram_dq_oe,
        output sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
    );

    modport slave (
        output cpu_rd, cpu_wt, cpu_byte, cpu_adr, cpu_data_i,
        output vid_req, vid_adr, sram_dq_i,
        input  cpu_data_o, cpu_reply, vid_data, vid_ack,
        input  sram_a, sram_dq_o, sram_dq_oe,
        input  sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
    );
endinterface

// File: rtl/bk_sram_arbiter.sv
// BK SRAM arbiter: shares one 16-bit SRAM between CPU and video fetch.
// All SRAM strobes are registered and move only on state/count changes.
module bk_sram_arbiter #(
    parameter int SRAM_LAT = 2
) (
    input logic               clk,
    input logic               reset_n,
    bk_sram_arbiter_if.master bus
);
    localparam int CW = (SRAM_LAT > 1) ? $clog2(SRAM_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SRAM_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        VID,
        CPU_RD,
        CPU_WR,
        CPU_HOLD
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          last_vid;
    logic          last_vid_nxt;

    logic          reply_q, reply_nxt;
    logic          ack_q, ack_nxt;
    logic [15:0]   cdata_q, cdata_nxt;
    logic [15:0]   vdata_q, vdata_nxt;
    logic [14:0]   a_q, a_nxt;
    logic [15:0]   dqo_q, dqo_nxt;
    logic          dqoe_q, dqoe_nxt;
    logic          oen_q, oen_nxt;
    logic          wen_q, wen_nxt;
    logic          ubn_q, ubn_nxt;
    logic          lbn_q, lbn_nxt;

    logic          cpu_any;
    logic          cpu_req;
    logic          cnt_zero;
    logic          in_access;

    assign cpu_any   = bus.cpu_rd | bus.cpu_wt;
    assign cpu_req   = cpu_any & ~reply_q;
    assign cnt_zero  = (cnt == '0);
    assign in_access = (state == VID) || (state == CPU_RD) ||
                       (state == CPU_WR);

    // state, counter, arbitration history and all registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            last_vid <= 1'b0;
            reply_q  <= 1'b0;
            ack_q    <= 1'b0;
            cdata_q  <= 16'h0000;
            vdata_q  <= 16'h0000;
            a_q      <= 15'h0000;
            dqo_q    <= 16'h0000;
            dqoe_q   <= 1'b0;
            oen_q    <= 1'b1;
            wen_q    <= 1'b1;
            ubn_q    <= 1'b1;
            lbn_q    <= 1'b1;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            last_vid <= last_vid_nxt;
            reply_q  <= reply_nxt;
            ack_q    <= ack_nxt;
            cdata_q  <= cdata_nxt;
            vdata_q  <= vdata_nxt;
            a_q      <= a_nxt;
            dqo_q    <= dqo_nxt;
            dqoe_q   <= dqoe_nxt;
            oen_q    <= oen_nxt;
            wen_q    <= wen_nxt;
            ubn_q    <= ubn_nxt;
            lbn_q    <= lbn_nxt;
        end
    end

    // arbitration and access sequencing; video and CPU alternate on contention
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        last_vid_nxt = last_vid;
        case (state)
            IDLE: begin
                if (bus.vid_req && (!cpu_req || !last_vid)) begin
                    state_nxt = VID;
                    cnt_nxt   = CNT_LOAD;
                end else if (cpu_req && bus.cpu_wt) begin
                    state_nxt = CPU_WR;
                    cnt_nxt   = CNT_LOAD;
                end else if (cpu_req && bus.cpu_rd) begin
                    state_nxt = CPU_RD;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            VID: begin
                if (cnt_zero) begin
                    state_nxt    = IDLE;
                    last_vid_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            CPU_RD, CPU_WR: begin
                if (cnt_zero) begin
                    state_nxt    = CPU_HOLD;
                    last_vid_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            CPU_HOLD: begin
                if (!cpu_any) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // next values of strobes, data capture and CPU/video handshakes
    always_comb begin
        reply_nxt = reply_q;
        ack_nxt   = 1'b0;
        cdata_nxt = cdata_q;
        vdata_nxt = vdata_q;
        a_nxt     = a_q;
        dqo_nxt   = dqo_q;
        dqoe_nxt  = dqoe_q;
        oen_nxt   = oen_q;
        wen_nxt   = wen_q;
        ubn_nxt   = ubn_q;
        lbn_nxt   = lbn_q;
        if (state == IDLE) begin
            case (state_nxt)
                VID: begin
                    a_nxt   = bus.vid_adr;
                    oen_nxt = 1'b0;
                    ubn_nxt = 1'b0;
                    lbn_nxt = 1'b0;
                end
                CPU_RD: begin
                    a_nxt   = bus.cpu_adr[15:1];
                    oen_nxt = 1'b0;
                    ubn_nxt = 1'b0;
                    lbn_nxt = 1'b0;
                end
                CPU_WR: begin
                    a_nxt    = bus.cpu_adr[15:1];
                    dqo_nxt  = bus.cpu_data_i;
                    dqoe_nxt = 1'b1;
                    wen_nxt  = 1'b0;
                    ubn_nxt  = bus.cpu_byte & ~bus.cpu_adr[0];
                    lbn_nxt  = bus.cpu_byte & bus.cpu_adr[0];
                end
                default: begin
                end
            endcase
        end
        if (in_access && cnt_zero) begin
            oen_nxt  = 1'b1;
            wen_nxt  = 1'b1;
            dqoe_nxt = 1'b0;
            ubn_nxt  = 1'b1;
            lbn_nxt  = 1'b1;
        end
        if ((state == VID) && cnt_zero) begin
            vdata_nxt = bus.sram_dq_i;
            ack_nxt   = 1'b1;
        end
        if ((state == CPU_RD) && cnt_zero) begin
            cdata_nxt = bus.sram_dq_i;
        end
        if (((state == CPU_RD) || (state == CPU_WR)) && cnt_zero) begin
            reply_nxt = cpu_any;
        end
        if ((state == CPU_HOLD) && !cpu_any) begin
            reply_nxt = 1'b0;
        end
    end

    assign bus.cpu_reply  = reply_q;
    assign bus.cpu_data_o = cdata_q;
    assign bus.vid_ack    = ack_q;
    assign bus.vid_data   = vdata_q;
    assign bus.sram_a     = a_q;
    assign bus.sram_dq_o  = dqo_q;
    assign bus.sram_dq_oe = dqoe_q;
    assign bus.sram_oe_n  = oen_q;
    assign bus.sram_we_n  = wen_q;
    assign bus.sram_ub_n  = ubn_q;
    assign bus.sram_lb_n  = lbn_q;
endmodule

// File: tb/tb_bk_sram_arbiter.sv
// Bench for bk_sram_arbiter: SRAM model, reference memory, scoreboard.
// Directed scenarios followed by concurrent random CPU/video traffic.
module tb_bk_sram_arbiter;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    bk_sram_arbiter_if bus();

    bk_sram_arbiter #(.SRAM_LAT(LAT)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    typedef struct {
        bit          rd;
        logic [15:0] d;
    } cexp_t;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] mem [0:32767];
    logic [15:0] ref_mem [0:32767];
    cexp_t       cpu_q[$];
    logic [15:0] vid_q[$];
    byte         ev_log[$];
    logic        ub_seen = 1'b1;
    logic        lb_seen = 1'b1;
    logic        prev_reply = 1'b0;

    function automatic logic [15:0] init_val(int i);
        return 16'((i * 40503) ^ 23130);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // SRAM: writes lanes when we_n sampled low; reads are asynchronous
    initial begin
        for (int i = 0; i < 32768; i++) begin
            mem[i]     = init_val(i);
            ref_mem[i] = init_val(i);
        end
        forever begin
            @(posedge clk);
            if (!bus.sram_we_n) begin
                if (!bus.sram_ub_n) mem[bus.sram_a][15:8] <= bus.sram_dq_o[15:8];
                if (!bus.sram_lb_n) mem[bus.sram_a][7:0] <= bus.sram_dq_o[7:0];
            end
        end
    end

    assign bus.sram_dq_i = bus.sram_oe_n ? 16'hDEAD : mem[bus.sram_a];

    // monitor: pops expectations on vid_ack and on cpu_reply rising
    initial begin
        forever begin
            @(negedge clk);
            if (bus.vid_ack) begin
                ev_log.push_back("V");
                if (vid_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL vid_unexpected: ack with %h, none expected", bus.vid_data);
                end else begin
                    chk("vid_data", bus.vid_data, vid_q.pop_front());
                end
            end
            if (bus.cpu_reply && !prev_reply) begin
                ev_log.push_back("C");
                if (cpu_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL cpu_unexpected: reply got 1, expected 0");
                end else begin
                    cexp_t e;
                    e = cpu_q.pop_front();
                    if (e.rd) chk("cpu_data", bus.cpu_data_o, e.d);
                end
            end
            prev_reply = bus.cpu_reply;
            chk("dq_oe_vs_we", bus.sram_dq_oe, !bus.sram_we_n);
            chk("oe_we_excl", !bus.sram_oe_n && !bus.sram_we_n, 0);
            if (!bus.sram_we_n) begin
                ub_seen = bus.sram_ub_n;
                lb_seen = bus.sram_lb_n;
            end
        end
    end

    task automatic cpu_access(input bit wr, input bit bt, input logic [15:0] adr,
                              input logic [15:0] data, output int lat);
        cexp_t       e;
        logic [14:0] w;
        int          k;
        w    = adr[15:1];
        e.rd = !wr;
        e.d  = 16'h0000;
        if (wr) begin
            if (!bt || adr[0]) ref_mem[w][15:8] = data[15:8];
            if (!bt || !adr[0]) ref_mem[w][7:0] = data[7:0];
        end else begin
            e.d = ref_mem[w];
        end
        cpu_q.push_back(e);
        bus.cpu_adr    = adr;
        bus.cpu_data_i = data;
        bus.cpu_byte   = bt;
        bus.cpu_wt     = wr;
        bus.cpu_rd     = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.cpu_reply && lat < 60);
        if (!bus.cpu_reply) begin
            n_chk++;
            n_fail++;
            $display("FAIL cpu_timeout: reply got 0 after %0d cycles, expected 1", lat);
        end
        bus.cpu_rd = 1'b0;
        bus.cpu_wt = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.cpu_reply && k < 20);
        if (bus.cpu_reply) begin
            n_chk++;
            n_fail++;
            $display("FAIL cpu_reply_stuck: reply got 1, expected 0");
        end
    endtask

    task automatic vid_fetch(input logic [14:0] adr, input bit keep, output int lat);
        vid_q.push_back(ref_mem[adr]);
        bus.vid_adr = adr;
        bus.vid_req = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.vid_ack && lat < 60);
        if (!bus.vid_ack) begin
            n_chk++;
            n_fail++;
            $display("FAIL vid_timeout: ack got 0 after %0d cycles, expected 1", lat);
        end
        if (!keep) bus.vid_req = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int lat2;
        bus.cpu_rd     = 1'b0;
        bus.cpu_wt     = 1'b0;
        bus.cpu_byte   = 1'b0;
        bus.cpu_adr    = 16'h0000;
        bus.cpu_data_i = 16'h0000;
        bus.vid_req    = 1'b0;
        bus.vid_adr    = 15'h0000;

        #2 reset_n = 1'b0;
        #1;
        chk("rst_reply", bus.cpu_reply, 0);
        chk("rst_ack", bus.vid_ack, 0);
        chk("rst_cdata", bus.cpu_data_o, 0);
        chk("rst_vdata", bus.vid_data, 0);
        chk("rst_a", bus.sram_a, 0);
        chk("rst_dq_o", bus.sram_dq_o, 0);
        chk("rst_dq_oe", bus.sram_dq_oe, 0);
        chk("rst_strobes", {bus.sram_oe_n, bus.sram_we_n, bus.sram_ub_n, bus.sram_lb_n}, 4'hF);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // reset in the middle of a write
        bus.cpu_adr    = 16'h6000;
        bus.cpu_data_i = 16'h5555;
        bus.cpu_wt     = 1'b1;
        @(negedge clk);
        chk("t1_we_active", bus.sram_we_n, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("t1_we_n", bus.sram_we_n, 1);
        chk("t1_dq_oe", bus.sram_dq_oe, 0);
        chk("t1_reply", bus.cpu_reply, 0);
        chk("t1_oe_n", bus.sram_oe_n, 1);
        bus.cpu_wt = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // word write / read latency and data
        cpu_access(1'b1, 1'b0, 16'o001000, 16'h1234, lat);
        chk("t2_wr_lat", lat, LAT + 1);
        cpu_access(1'b0, 1'b0, 16'o001000, 16'h0000, lat);
        chk("t2_rd_lat", lat, LAT + 1);
        chk("t2_rd_data", bus.cpu_data_o, 16'h1234);

        // byte writes select one lane each
        cpu_access(1'b1, 1'b1, 16'o001001, 16'hABAB, lat);
        chk("t3_ub_odd", ub_seen, 0);
        chk("t3_lb_odd", lb_seen, 1);
        cpu_access(1'b0, 1'b0, 16'o001000, 16'h0000, lat);
        chk("t3_rd_odd", bus.cpu_data_o, 16'hAB34);
        cpu_access(1'b1, 1'b1, 16'o001000, 16'hCDCD, lat);
        chk("t3_ub_even", ub_seen, 1);
        chk("t3_lb_even", lb_seen, 0);
        cpu_access(1'b0, 1'b0, 16'o001000, 16'h0000, lat);
        chk("t3_rd_even", bus.cpu_data_o, 16'hABCD);

        // simultaneous request after a CPU access: video first
        for (int r = 0; r < 2; r++) begin
            fork
                vid_fetch(15'h0100, 1'b0, lat);
                cpu_access(1'b0, 1'b0, 16'o001000, 16'h0000, lat2);
            join
            chk("t4_vid_lat", lat, LAT + 1);
            chk("t4_cpu_lat", lat2, 2 * (LAT + 1));
            repeat (2) @(negedge clk);
        end

        // continuous contention alternates V,C,V,C,V
        ev_log.delete();
        fork
            begin
                vid_fetch(15'h4001, 1'b1, lat);
                vid_fetch(15'h4002, 1'b1, lat);
                vid_fetch(15'h4003, 1'b0, lat);
            end
            begin
                cpu_access(1'b0, 1'b0, 16'h0010, 16'h0000, lat2);
                cpu_access(1'b0, 1'b0, 16'h0012, 16'h0000, lat2);
            end
        join
        repeat (3) @(negedge clk);
        begin
            byte exp_seq [5] = '{"V", "C", "V", "C", "V"};
            chk("t4_order_len", ev_log.size(), 5);
            for (int i = 0; i < 5; i++) begin
                if (i < ev_log.size()) chk("t4_order", ev_log[i], exp_seq[i]);
            end
        end

        // back-to-back video fetches
        for (int i = 0; i < 4; i++) begin
            vid_fetch(15'h4000 | 15'($urandom_range(0, 16383)), i < 3, lat);
            chk("t5_vid_lat", lat, LAT + 1);
        end
        repeat (3) @(negedge clk);

        // read dropped mid-access
        bus.cpu_adr  = 16'o001000;
        bus.cpu_byte = 1'b0;
        bus.cpu_rd   = 1'b1;
        @(negedge clk);
        chk("t6_oe_active", bus.sram_oe_n, 0);
        bus.cpu_rd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_no_reply", bus.cpu_reply, 0);
        end
        chk("t6_oe_off", bus.sram_oe_n, 1);
        cpu_access(1'b0, 1'b0, 16'o001000, 16'h0000, lat);
        chk("t6_next_lat", lat, LAT + 1);

        // random concurrent traffic
        fork
            begin
                int l;
                for (int i = 0; i < 40; i++) begin
                    bit          wr;
                    bit          bt;
                    logic [15:0] d;
                    wr = 1'($urandom_range(0, 1));
                    bt = 1'($urandom_range(0, 1));
                    d  = 16'($urandom);
                    if (bt) d = {d[7:0], d[7:0]};
                    cpu_access(wr, bt, 16'($urandom_range(0, 63)), d, l);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
            begin
                int l;
                for (int i = 0; i < 40; i++) begin
                    bit keep;
                    keep = (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
                    vid_fetch(15'h4000 | 15'($urandom_range(0, 16383)), keep, l);
                    if (!keep) repeat ($urandom_range(0, 4)) @(negedge clk);
                end
            end
        join

        repeat (10) @(negedge clk);
        chk("cpu_q_empty", cpu_q.size(), 0);
        chk("vid_q_empty", vid_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
